// File: rtl/mc_controller_if.sv
// Control bundle between the multi-cycle controller and the IFU/datapath.
// The master side is the controller; the slave side is the IFU/datapath (or a bench).
interface mc_controller_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             zero;
  logic             IntReq;
  logic             PCWr;
  logic             IRWr;
  logic [2:0]       NPCSel;
  logic             RegWr;
  logic [1:0]       RegDst;
  logic [1:0]       WDSel;
  logic             ALUSrc;
  logic             ExtOp;
  logic [2:0]       ALUOp;
  logic             MemWr;
  logic             EPCWr;
  logic [3:0]       state;
  logic [CNT_W-1:0] instret;

  modport master (
    input  op, funct, zero, IntReq,
    output PCWr, IRWr, NPCSel, RegWr, RegDst, WDSel, ALUSrc, ExtOp, ALUOp,
           MemWr, EPCWr, state, instret
  );

  modport slave (
    output op, funct, zero, IntReq,
    input  PCWr, IRWr, NPCSel, RegWr, RegDst, WDSel, ALUSrc, ExtOp, ALUOp,
           MemWr, EPCWr, state, instret
  );
endinterface

// File: rtl/mc_controller.sv
// Multi-cycle MIPS-subset control FSM with retired-instruction counter.
// Optional interrupt entry state enabled by defining MC_CTRL_INT_EN.
module mc_controller #(
  parameter int CNT_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  mc_controller_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_MEM_RD = 4'd3,
    S_MEM_WR = 4'd4,
    S_WB_ALU = 4'd5,
    S_WB_MEM = 4'd6,
    S_BRANCH = 4'd7,
    S_JUMP   = 4'd8,
    S_INT    = 4'd9
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r, next_state_s, retire_next_s;
  logic [CNT_W-1:0] instret_r;
  logic             retire_s;

  logic is_r_s, is_addu_s, is_subu_s, is_jr_s, is_ori_s, is_lui_s;
  logic is_lw_s, is_sw_s, is_beq_s, is_j_s, is_jal_s, is_alu_class_s, is_jump_s;

  logic [2:0] alu_op_s;
  logic       alu_src_s, ext_op_s;

  logic       pc_wr_s, ir_wr_s, reg_wr_s, mem_wr_s, epc_wr_s;
  logic [2:0] npc_sel_s, alu_op_out_s;
  logic [1:0] reg_dst_s, wd_sel_s;
  logic       alu_src_out_s, ext_op_out_s;

  // Instruction class decode from the stored opcode/funct fields
  always_comb begin
    is_r_s         = (bus.op == 6'b000000);
    is_addu_s      = is_r_s && (bus.funct == 6'b100001);
    is_subu_s      = is_r_s && (bus.funct == 6'b100011);
    is_jr_s        = is_r_s && (bus.funct == 6'b001000);
    is_ori_s       = (bus.op == 6'b001101);
    is_lui_s       = (bus.op == 6'b001111);
    is_lw_s        = (bus.op == 6'b100011);
    is_sw_s        = (bus.op == 6'b101011);
    is_beq_s       = (bus.op == 6'b000100);
    is_j_s         = (bus.op == 6'b000010);
    is_jal_s       = (bus.op == 6'b000011);
    is_alu_class_s = is_addu_s | is_subu_s | is_ori_s | is_lui_s | is_lw_s | is_sw_s;
    is_jump_s      = is_j_s | is_jal_s | is_jr_s;
  end

  // ALU setup shared by EXEC and the states that hold EXEC's controls
  always_comb begin
    alu_op_s  = 3'd0;
    alu_src_s = 1'b0;
    ext_op_s  = 1'b0;
    if (is_subu_s) begin
      alu_op_s = 3'd1;
    end else if (is_ori_s) begin
      alu_op_s  = 3'd2;
      alu_src_s = 1'b1;
    end else if (is_lui_s) begin
      alu_op_s  = 3'd3;
      alu_src_s = 1'b1;
    end else if (is_lw_s || is_sw_s) begin
      alu_src_s = 1'b1;
      ext_op_s  = 1'b1;
    end else begin
      alu_op_s = 3'd0;
    end
  end

`ifdef MC_CTRL_INT_EN
  assign retire_next_s = bus.IntReq ? S_INT : S_FETCH;
`else
  logic int_req_unused_s;
  assign int_req_unused_s = bus.IntReq;
  assign retire_next_s    = S_FETCH;
`endif

  // Moore output decode and next-state selection
  always_comb begin
    next_state_s  = S_FETCH;
    retire_s      = 1'b0;
    pc_wr_s       = 1'b0;
    ir_wr_s       = 1'b0;
    npc_sel_s     = 3'd0;
    reg_wr_s      = 1'b0;
    reg_dst_s     = 2'd0;
    wd_sel_s      = 2'd0;
    alu_src_out_s = 1'b0;
    ext_op_out_s  = 1'b0;
    alu_op_out_s  = 3'd0;
    mem_wr_s      = 1'b0;
    epc_wr_s      = 1'b0;
    case (state_r)
      S_FETCH: begin
        pc_wr_s      = 1'b1;
        ir_wr_s      = 1'b1;
        next_state_s = S_DECODE;
      end
      S_DECODE: begin
        if (is_alu_class_s) begin
          next_state_s = S_EXEC;
        end else if (is_beq_s) begin
          next_state_s = S_BRANCH;
        end else if (is_jump_s) begin
          next_state_s = S_JUMP;
        end else begin
          // unsupported encodings retire as a nop
          retire_s     = 1'b1;
          next_state_s = retire_next_s;
        end
      end
      S_EXEC: begin
        alu_op_out_s  = alu_op_s;
        alu_src_out_s = alu_src_s;
        ext_op_out_s  = ext_op_s;
        if (is_lw_s) begin
          next_state_s = S_MEM_RD;
        end else if (is_sw_s) begin
          next_state_s = S_MEM_WR;
        end else begin
          next_state_s = S_WB_ALU;
        end
      end
      S_MEM_RD: begin
        alu_op_out_s  = alu_op_s;
        alu_src_out_s = alu_src_s;
        ext_op_out_s  = ext_op_s;
        next_state_s  = S_WB_MEM;
      end
      S_MEM_WR: begin
        mem_wr_s      = 1'b1;
        alu_op_out_s  = alu_op_s;
        alu_src_out_s = alu_src_s;
        ext_op_out_s  = ext_op_s;
        retire_s      = 1'b1;
        next_state_s  = retire_next_s;
      end
      S_WB_ALU: begin
        reg_wr_s      = 1'b1;
        reg_dst_s     = is_r_s ? 2'd1 : 2'd0;
        alu_op_out_s  = alu_op_s;
        alu_src_out_s = alu_src_s;
        ext_op_out_s  = ext_op_s;
        retire_s      = 1'b1;
        next_state_s  = retire_next_s;
      end
      S_WB_MEM: begin
        reg_wr_s     = 1'b1;
        wd_sel_s     = 2'd1;
        retire_s     = 1'b1;
        next_state_s = retire_next_s;
      end
      S_BRANCH: begin
        alu_op_out_s = 3'd1;
        ext_op_out_s = 1'b1;
        npc_sel_s    = 3'd3;
        pc_wr_s      = bus.zero;
        retire_s     = 1'b1;
        next_state_s = retire_next_s;
      end
      S_JUMP: begin
        pc_wr_s = 1'b1;
        if (is_jal_s) begin
          npc_sel_s = 3'd2;
          reg_wr_s  = 1'b1;
          reg_dst_s = 2'd2;
          wd_sel_s  = 2'd2;
        end else if (is_jr_s) begin
          npc_sel_s = 3'd1;
        end else begin
          npc_sel_s = 3'd2;
        end
        retire_s     = 1'b1;
        next_state_s = retire_next_s;
      end
`ifdef MC_CTRL_INT_EN
      S_INT: begin
        pc_wr_s      = 1'b1;
        npc_sel_s    = 3'd4;
        epc_wr_s     = 1'b1;
        next_state_s = S_FETCH;
      end
`endif
      default: begin
        next_state_s = S_FETCH;
      end
    endcase
  end

  // State register and retired-instruction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_FETCH;
      instret_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      if (retire_s) begin
        instret_r <= instret_r + CNT_ONE;
      end else begin
        instret_r <= instret_r;
      end
    end
  end

  // Reset holds every write enable low so an abandoned instruction writes nothing
  assign bus.PCWr    = reset ? 1'b0 : pc_wr_s;
  assign bus.IRWr    = reset ? 1'b0 : ir_wr_s;
  assign bus.NPCSel  = reset ? 3'd0 : npc_sel_s;
  assign bus.RegWr   = reset ? 1'b0 : reg_wr_s;
  assign bus.MemWr   = reset ? 1'b0 : mem_wr_s;
  assign bus.EPCWr   = reset ? 1'b0 : epc_wr_s;
  assign bus.RegDst  = reg_dst_s;
  assign bus.WDSel   = wd_sel_s;
  assign bus.ALUSrc  = alu_src_out_s;
  assign bus.ExtOp   = ext_op_out_s;
  assign bus.ALUOp   = alu_op_out_s;
  assign bus.state   = state_r;
  assign bus.instret = instret_r;
endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-cycle expected state/controls are
// queued from an instruction-level model and popped as the DUT steps.
module tb_mc_controller;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [31:0] exp_instret;

  typedef struct packed {
    logic [3:0]  st;
    logic [16:0] ctl;
  } exp_t;

  exp_t sb[$];

  mc_controller_if #(.CNT_W(32)) bus();

  mc_controller #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // {PCWr, IRWr, NPCSel, RegWr, RegDst, WDSel, ALUSrc, ExtOp, ALUOp, MemWr, EPCWr}
  function automatic logic [16:0] mk(input logic pcwr, input logic irwr, input logic [2:0] npc,
                                     input logic regwr, input logic [1:0] regdst,
                                     input logic [1:0] wdsel, input logic alusrc,
                                     input logic extop, input logic [2:0] aluop,
                                     input logic memwr, input logic epcwr);
    return {pcwr, irwr, npc, regwr, regdst, wdsel, alusrc, extop, aluop, memwr, epcwr};
  endfunction

  function automatic logic [16:0] dut_ctl();
    return {bus.PCWr, bus.IRWr, bus.NPCSel, bus.RegWr, bus.RegDst, bus.WDSel,
            bus.ALUSrc, bus.ExtOp, bus.ALUOp, bus.MemWr, bus.EPCWr};
  endfunction

  task automatic push(input logic [3:0] st, input logic [16:0] ctl);
    exp_t e;
    e.st  = st;
    e.ctl = ctl;
    sb.push_back(e);
  endtask

  // Instruction-level reference: expected cycle-by-cycle states and controls
  task automatic push_model(input logic [5:0] o, input logic [5:0] f, input logic z, input logic irq);
    logic [2:0] aop;
    logic       src, ext;
    logic       alu_class;
    logic       is_r;
    is_r = (o == 6'd0);
    alu_class = 1'b1;
    aop = 3'd0; src = 1'b0; ext = 1'b0;
    if (is_r && f == 6'h21) begin aop = 3'd0; end
    else if (is_r && f == 6'h23) begin aop = 3'd1; end
    else if (o == 6'h0d) begin aop = 3'd2; src = 1'b1; end
    else if (o == 6'h0f) begin aop = 3'd3; src = 1'b1; end
    else if (o == 6'h23 || o == 6'h2b) begin aop = 3'd0; src = 1'b1; ext = 1'b1; end
    else alu_class = 1'b0;

    push(4'd0, mk(1, 1, 3'd0, 0, 2'd0, 2'd0, 0, 0, 3'd0, 0, 0));
    push(4'd1, 17'd0);
    if (alu_class) begin
      push(4'd2, mk(0, 0, 3'd0, 0, 2'd0, 2'd0, src, ext, aop, 0, 0));
      if (o == 6'h23) begin
        push(4'd3, mk(0, 0, 3'd0, 0, 2'd0, 2'd0, src, ext, aop, 0, 0));
        push(4'd6, mk(0, 0, 3'd0, 1, 2'd0, 2'd1, 0, 0, 3'd0, 0, 0));
      end else if (o == 6'h2b) begin
        push(4'd4, mk(0, 0, 3'd0, 0, 2'd0, 2'd0, src, ext, aop, 1, 0));
      end else begin
        push(4'd5, mk(0, 0, 3'd0, 1, is_r ? 2'd1 : 2'd0, 2'd0, src, ext, aop, 0, 0));
      end
    end else if (o == 6'h04) begin
      push(4'd7, mk(z, 0, 3'd3, 0, 2'd0, 2'd0, 0, 1, 3'd1, 0, 0));
    end else if (o == 6'h02) begin
      push(4'd8, mk(1, 0, 3'd2, 0, 2'd0, 2'd0, 0, 0, 3'd0, 0, 0));
    end else if (o == 6'h03) begin
      push(4'd8, mk(1, 0, 3'd2, 1, 2'd2, 2'd2, 0, 0, 3'd0, 0, 0));
    end else if (is_r && f == 6'h08) begin
      push(4'd8, mk(1, 0, 3'd1, 0, 2'd0, 2'd0, 0, 0, 3'd0, 0, 0));
    end
`ifdef MC_CTRL_INT_EN
    if (irq) push(4'd9, mk(1, 0, 3'd4, 0, 2'd0, 2'd0, 0, 0, 3'd0, 0, 1));
`else
    if (irq) aop = 3'd0;
`endif
  endtask

  // Drive one instruction starting at a FETCH-cycle negedge and score every cycle
  task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                           input logic z, input logic irq);
    exp_t e;
    bus.op = o; bus.funct = f; bus.zero = z; bus.IntReq = irq;
    push_model(o, f, z, irq);
    while (sb.size() > 0) begin
      #1;
      e = sb.pop_front();
      check_eq({name, "/state"}, {28'd0, bus.state}, {28'd0, e.st});
      check_eq({name, "/ctl"}, {15'd0, dut_ctl()}, {15'd0, e.ctl});
      @(negedge clk);
    end
    bus.IntReq = 1'b0;
    exp_instret = exp_instret + 32'd1;
    #1;
    check_eq({name, "/instret"}, bus.instret, exp_instret);
    check_eq({name, "/back_to_fetch"}, {28'd0, bus.state}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.op = 6'h23; bus.funct = 6'd0; bus.zero = 1'b0; bus.IntReq = 1'b0;
    exp_instret = 32'd0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check_eq("reset/enables", {27'd0, bus.PCWr, bus.IRWr, bus.RegWr, bus.MemWr, bus.EPCWr}, 32'd0);
      check_eq("reset/npcsel", {29'd0, bus.NPCSel}, 32'd0);
    end
    reset = 1'b0;
    #1;
    check_eq("reset/state", {28'd0, bus.state}, 32'd0);
    check_eq("reset/instret", bus.instret, 32'd0);

    run_instr("addu", 6'h00, 6'h21, 1'b0, 1'b0);
    run_instr("subu", 6'h00, 6'h23, 1'b1, 1'b0);
    run_instr("ori",  6'h0d, 6'h3f, 1'b0, 1'b0);
    run_instr("lui",  6'h0f, 6'h00, 1'b0, 1'b0);
    run_instr("lw",   6'h23, 6'h00, 1'b0, 1'b0);
    run_instr("sw",   6'h2b, 6'h00, 1'b0, 1'b0);
    run_instr("beq_t", 6'h04, 6'h00, 1'b1, 1'b0);
    run_instr("beq_nt", 6'h04, 6'h00, 1'b0, 1'b0);
    run_instr("j",    6'h02, 6'h00, 1'b0, 1'b0);
    run_instr("jal",  6'h03, 6'h00, 1'b0, 1'b0);
    run_instr("jr",   6'h00, 6'h08, 1'b0, 1'b0);
    run_instr("nop_op", 6'h3f, 6'h00, 1'b0, 1'b0);
    run_instr("nop_funct", 6'h00, 6'h20, 1'b0, 1'b0);
    run_instr("addu_irq", 6'h00, 6'h21, 1'b0, 1'b1);
    run_instr("lw_irq", 6'h23, 6'h00, 1'b0, 1'b1);

    // Reset during EXEC of addu abandons it and clears the counter
    bus.op = 6'h00; bus.funct = 6'h21;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("rst_mid/exec_state", {28'd0, bus.state}, 32'd2);
    check_eq("rst_mid/exec_ctl", {15'd0, dut_ctl()}, 32'd0);
    @(negedge clk);
    #1;
    check_eq("rst_mid/fetch_state", {28'd0, bus.state}, 32'd0);
    check_eq("rst_mid/no_regwr", {31'd0, bus.RegWr}, 32'd0);
    reset = 1'b0;
    exp_instret = 32'd0;
    #1;
    check_eq("rst_mid/instret", bus.instret, exp_instret);
    @(negedge clk);
    #1;
    check_eq("rst_mid/decode_state", {28'd0, bus.state}, 32'd1);
    // Realign to a FETCH cycle: DECODE of addu -> EXEC -> WB_ALU -> FETCH
    for (int k = 0; k < 3; k++) @(negedge clk);
    exp_instret = exp_instret + 32'd1;
    #1;
    check_eq("rst_mid/realign_state", {28'd0, bus.state}, 32'd0);
    check_eq("rst_mid/realign_instret", bus.instret, exp_instret);
    run_instr("addu_after_rst", 6'h00, 6'h21, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
